// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port round-robin arbiter and access sequencer in front of the
// single-ported 16-bit data memory. Port 0 is the CPU load/store unit and
// port 1 is the debug/DMA loader. One access is in flight at a time:
// grant (IDLE) -> memory cycle (ACCESS) -> completion pulse (DONE).
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   pN_req/we/addr/    request, op (1 = write), byte address, write data
//   pN_wdata
//   pN_gnt             request accepted this cycle (IDLE only)
//   pN_valid/err/      completion pulse, out-of-range flag, read data
//   pN_rdata
//   mem_rEnable/       memory strobes, driven for the single ACCESS cycle
//   mem_wEnable
//   mem_address/       latched address / write data of the current access
//   mem_wData
//   mem_rData          combinational read data from the memory
//
// state  | meaning
// IDLE   | waiting for a request; winner is granted and latched here
// ACCESS | one memory cycle with the latched address/data
// DONE   | completion pulse returned to the latched port
module dmem_arbiter #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 16,
  parameter int unsigned MEM_TOP = 10000
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_valid,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_valid,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_rEnable,
  output logic              mem_wEnable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wData,
  input  logic [DATA_W-1:0] mem_rData
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic              prio;
  logic              port_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W:0]   sel_last;
  logic              sel_ok;
  logic              done;

  // Winner: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    any_req   = p0_req | p1_req;
    win       = (p0_req && p1_req) ? prio : p1_req;
    sel_we    = win ? p1_we    : p0_we;
    sel_addr  = win ? p1_addr  : p0_addr;
    sel_wdata = win ? p1_wdata : p0_wdata;
    // Second byte of the word must still be below MEM_TOP; widened so
    // 0xFFFF does not wrap back into range.
    sel_last  = {1'b0, sel_addr} + {{ADDR_W{1'b0}}, 1'b1};
    sel_ok    = 32'(sel_last) < MEM_TOP;
  end

  // Grant has to be visible in the same cycle the request is sampled, so
  // it is decoded from the current state rather than registered.
  assign p0_gnt = (state == IDLE) && any_req && !win;
  assign p1_gnt = (state == IDLE) && any_req &&  win;

  assign done     = (state == DONE);
  assign p0_valid = done && !port_q;
  assign p1_valid = done &&  port_q;
  assign p0_err   = p0_valid && err_q;
  assign p1_err   = p1_valid && err_q;
  assign p0_rdata = p0_valid ? rdata_q : '0;
  assign p1_rdata = p1_valid ? rdata_q : '0;

  assign mem_address = addr_q;
  assign mem_wData   = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      port_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_rEnable <= 1'b0;
      mem_wEnable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q      <= win;
            prio        <= ~win;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            err_q       <= !sel_ok;
            // Strobes are set up here so they are high for exactly the
            // ACCESS cycle and never for an out-of-range address.
            mem_rEnable <= sel_ok && !sel_we;
            mem_wEnable <= sel_ok &&  sel_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_rEnable <= 1'b0;
          mem_wEnable <= 1'b0;
          // Writes and errors report zero read data.
          rdata_q     <= mem_rEnable ? mem_rData : '0;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem_rEnable <= 1'b0;
          mem_wEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_valid, p0_err, p1_gnt, p1_valid, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_rEnable, mem_wEnable;
  logic [15:0] mem_address, mem_wData, mem_rData;

  int checks = 0;
  int failures = 0;
  int wen_count = 0;
  int both_high = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_TOP(10000)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_valid(p0_valid), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_valid(p1_valid), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_rEnable(mem_rEnable), .mem_wEnable(mem_wEnable),
    .mem_address(mem_address), .mem_wData(mem_wData), .mem_rData(mem_rData)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory model, MSB at the lower address.
  logic [7:0] mem [0:9999];
  bit loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 10000; i++) mem[i] <= 8'h00;
      mem[0]    <= 8'h2b; mem[1]    <= 8'hcd;
      mem[4]    <= 8'h12; mem[5]    <= 8'h34;
      mem[8]    <= 8'hbe; mem[9]    <= 8'hef;
      mem[9998] <= 8'h5a; mem[9999] <= 8'h3c;
      loaded <= 1'b1;
    end else if (mem_wEnable && (32'(mem_address) + 1 < 10000)) begin
      mem[mem_address]     <= mem_wData[15:8];
      mem[mem_address + 1] <= mem_wData[7:0];
    end
  end

  always_comb begin
    mem_rData = 16'h0000;
    if (mem_rEnable && (32'(mem_address) + 1 < 10000))
      mem_rData = {mem[mem_address], mem[mem_address + 1]};
  end

  always @(posedge clk) if (mem_wEnable) wen_count++;
  always @(negedge clk) if (mem_rEnable && mem_wEnable) both_high++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs[9];

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    bit got;
    int wen0;
    @(posedge clk); #1;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((v.port ? p1_gnt : p0_gnt) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, " gnt"}, 32'(got), 32'd1);
    if (!got) begin
      drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
      return;
    end
    chk({nm, " other_gnt"}, 32'(v.port ? p0_gnt : p1_gnt), 32'd0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    wen0 = wen_count;
    @(negedge clk);
    chk({nm, " rEnable"}, 32'(mem_rEnable), 32'(!v.we && !v.err));
    chk({nm, " wEnable"}, 32'(mem_wEnable), 32'(v.we && !v.err));
    if (!v.err) chk({nm, " address"}, 32'(mem_address), 32'(v.addr));
    chk({nm, " early_valid"}, 32'(p0_valid | p1_valid), 32'd0);
    @(negedge clk);
    chk({nm, " valid"}, 32'(v.port ? p1_valid : p0_valid), 32'd1);
    chk({nm, " other_valid"}, 32'(v.port ? p0_valid : p1_valid), 32'd0);
    chk({nm, " err"}, 32'(v.port ? p1_err : p0_err), 32'(v.err));
    chk({nm, " rdata"}, 32'(v.port ? p1_rdata : p0_rdata), 32'(v.rdata));
    chk({nm, " write_cycles"}, 32'(wen_count - wen0), 32'(v.we && !v.err));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst outputs", 32'({p0_gnt, p0_valid, p0_err, p1_gnt, p1_valid, p1_err,
                            mem_rEnable, mem_wEnable}), 32'd0);
    chk("rst rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    chk("rst mem_bus", 32'({mem_address, mem_wData}), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2bcd, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'hA55A, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hA55A, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h270F, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h270E, 16'h0000, 16'h5a3c, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0011, 16'h1357, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h1357, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h0BAD, 16'h0000, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 16'h270F, 16'h7777, 16'h0000, 1'b1};

    apply_reset();

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Two continuous readers: strict alternation starting at port 0.
    apply_reset();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0008, 16'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("rr c%0d gnt0", c), 32'(p0_gnt), 32'(c % 6 == 0));
      chk($sformatf("rr c%0d gnt1", c), 32'(p1_gnt), 32'(c % 6 == 3));
      chk($sformatf("rr c%0d valid0", c), 32'(p0_valid), 32'(c % 6 == 2));
      chk($sformatf("rr c%0d valid1", c), 32'(p1_valid), 32'(c % 6 == 5));
      if (c % 6 == 2) chk($sformatf("rr c%0d rdata0", c), 32'(p0_rdata), 32'h1234);
      if (c % 6 == 5) chk($sformatf("rr c%0d rdata1", c), 32'(p1_rdata), 32'hbeef);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Lone port 1 right after its own grant: re-granted every 3 cycles.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("solo c%0d gnt1", c), 32'(p1_gnt), 32'(c % 3 == 0));
      chk($sformatf("solo c%0d gnt0", c), 32'(p0_gnt), 32'd0);
      chk($sformatf("solo c%0d valid1", c), 32'(p1_valid), 32'(c % 3 == 2));
      if (c % 3 == 2) chk($sformatf("solo c%0d rdata1", c), 32'(p1_rdata), 32'hA55A);
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset asserted during the ACCESS cycle of a write.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h0200, 16'hFFFF);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (p0_gnt === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst gnt", 32'(got), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("midrst wEnable_before", 32'(mem_wEnable), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst wEnable_after", 32'(mem_wEnable), 32'd0);
    chk("midrst rEnable_after", 32'(mem_rEnable), 32'd0);
    chk("midrst bus", 32'({mem_address, mem_wData}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("midrst c%0d no_valid", c), 32'(p0_valid | p1_valid), 32'd0);
    end
    run_vec("midrst readback", '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b0});

    chk("enables_exclusive", 32'(both_high), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
